dac_feed: RTL
=============

# dac_feed

Stereo sample feeder that sits directly upstream of the type9f PWM/delta-sigma DAC. It buffers 16-bit signed stereo samples from the audio source in a small FIFO and applies an 8-bit volume scale to produce 20-bit signed words. It then presents one word pair per output sample period on `dac_lch`/`dac_rch` with a one-cycle `dac_req` strobe. On FIFO underflow it outputs silence and sets a sticky flag.

## Interface
- `DEPTH`, 16: FIFO depth in stereo words; power of two, 4..256.
- `DIV`, 512: `dac_clk` cycles per output sample (48 kHz × 512 clock); must be ≥ 4.
- `dac_clk`  in  1  clock (48 kHz × 512).
- `dac_rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `en`  in  1  run enable for the sample pacer.
- `in_lch`  in  16  left sample, signed two's complement.
- `in_rch`  in  16  right sample, signed two's complement.
- `in_valid`  in  1  source has a sample pair.
- `in_ready`  out  1  FIFO can accept; a push occurs on `in_valid & in_ready`.
- `vol`  in  8  unsigned volume; 16 = unity on the 16-bit scale.
- `clr`  in  1  clears `underflow`.
- `level`  out  log2(DEPTH)+1  FIFO occupancy.
- `underflow`  out  1  sticky; set when a pop finds the FIFO empty.
- `dac_lch`  out  20  left output word, signed.
- `dac_rch`  out  20  right output word, signed.
- `dac_req`  out  1  one-cycle strobe; the DAC latches `dac_lch`/`dac_rch` in this cycle.

## Operation
- **FIFO**
  - Circular buffer of DEPTH entries, each 32 bits ({lch, rch}).
  - Write pointer, read pointer and `level` counter are registered.
  - `in_ready` = (`level` != DEPTH) & !`dac_rst`.
  - A push is accepted only when `in_ready` is high. A pop in the same cycle does not free a slot for a push when the FIFO is full.
- **Pacer**
  - 9-bit (log2 DIV) counter `div_cnt` counts 0..DIV-1 and wraps to 0.
  - `en`=0: `div_cnt` is held at 0, no pops occur, `dac_req`=0, and `dac_lch`/`dac_rch` hold their value.
- **Pop (fetch)**
  - Occurs on the edge where `div_cnt` == DIV-2 and `en`=1.
  - Level ≥ 1: read the head entry and advance the read pointer.
  - Level = 0: load zero into both outputs and set `underflow`.
  - Simultaneous push into an empty FIFO: the pop still sees empty (zero output, underflow set), the push is accepted, and `level` becomes 1.
  - Push and pop in the same cycle with 0 < level < DEPTH: `level` is unchanged.
- **Scale**
  - Output = (sample × {1'b0,`vol`}) arithmetic-shifted right by 4, truncated toward −∞.
  - Product is signed 25 bits; the result always fits 20 bits (extremes: −32768×255>>4 = −522240, 32767×255>>4 = 522224). No saturation is needed.
  - `vol` is sampled on the pop cycle. `vol`=0 gives 0.
- **Strobe**
  - `dac_req` is a register set to 1 on the edge where `div_cnt` goes DIV-1→0 with `en`=1, and is 0 otherwise.
  - `dac_lch`/`dac_rch` are therefore stable for at least one full cycle before `dac_req` and during it.
- **Underflow**
  - Set has priority over `clr` in the same cycle.
  - `clr` alone clears it on the next edge.

## Timing
- **Reset** (synchronous, edge with `dac_rst`=1): `div_cnt`=0, pointers=0, `level`=0, `dac_lch`=`dac_rch`=0, `dac_req`=0, `underflow`=0. `in_ready`=0 while `dac_rst` is high and 1 the cycle after.
- **Reset mid-operation**: FIFO contents are discarded; the first `dac_req` after release occurs DIV cycles after the first enabled cycle.
- **Latency**: a sample pushed into an empty FIFO at least 1 cycle before the fetch edge appears on the outputs at the fetch edge (`div_cnt` DIV-2 → DIV-1), and `dac_req` follows one cycle later.
- **Strobe period**: exactly DIV cycles while `en`=1.
- **`en` deasserted mid-period**: the partial period is abandoned; re-enable restarts a full DIV-cycle period.

## Test plan
- **Reset values**: assert `dac_rst` 3 cycles → all outputs 0, `in_ready`=0 during reset and 1 after.
- **Unity pass-through**: `vol`=16, push L=0x1234, R=0xFEDC (−292), `en`=1 → at first `dac_req` (cycle 512 after enable), `dac_lch`=0x01234, `dac_rch`=0xFFEDC; `level` returns to 0.
- **Scale extremes**: `vol`=255, push L=0x8000, R=0x7FFF → `dac_lch`=−522240 (0x80800), `dac_rch`=522224 (0x7F7F0); `vol`=0 → both 0.
- **Full/backpressure**: DEPTH=16, hold `in_valid`=1 with `en`=0 → exactly 16 pushes, `in_ready`=0, `level`=16; enable → `in_ready` rises the cycle after the first pop, and strobes occur every 512 cycles with samples in push order.
- **Underflow**: `en`=1 with empty FIFO → `dac_req` pulses with 0/0, `underflow`=1; pulse `clr` → 0; `clr` coincident with the next empty fetch → stays 1.
- **Corner cases**: push on the fetch cycle into an empty FIFO → zero output plus underflow, `level`=1, and the next period outputs that sample. Deassert `en` at `div_cnt`=300 and re-enable → the next `dac_req` comes 512 cycles after re-enable.

Source files
------------

// File: rtl/dac_feed.sv
// dac_feed: stereo sample FIFO, volume scaler and sample-rate pacer feeding
// the type9f DAC. One scaled word pair is fetched per output period and
// presented with a single-cycle dac_req strobe one cycle after the fetch.
module dac_feed #(
  parameter int DEPTH = 16,
  parameter int DIV   = 512
) (
  input  logic                     dac_clk,
  input  logic                     dac_rst,
  input  logic                     en,
  input  logic [15:0]              in_lch,
  input  logic [15:0]              in_rch,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               vol,
  input  logic                     clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic [19:0]              dac_lch,
  output logic [19:0]              dac_rch,
  output logic                     dac_req
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DIV);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_FETCH = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);

  // Sample storage: {lch, rch} per entry, no reset so it maps to block RAM.
  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [19:0]   lch_q, lch_d;
  logic [19:0]   rch_q, rch_d;
  logic          req_q, req_d;
  logic          uf_q, uf_d;

  logic          push;
  logic          fetch;
  logic          pop;
  logic [31:0]   head;
  logic [15:0]   smp    [2];
  logic [19:0]   scaled [2];

  // Full-FIFO backpressure; a same-cycle pop never opens a slot for a push.
  assign in_ready = (level_q != FULL_LVL) && !dac_rst;

  assign head   = mem_q[rd_ptr_q];
  assign smp[0] = head[31:16];
  assign smp[1] = head[15:0];

  // Per-channel volume scale: (sample * vol) >>> 4, floor rounding.
  // 24 bits hold every product (|-32768 * 255| < 2^23), so no saturation.
  for (genvar gi = 0; gi < 2; gi++) begin : g_scale
    logic signed [23:0] samp_ext;
    logic signed [23:0] vol_ext;
    logic signed [23:0] prod;
    assign samp_ext   = {{8{smp[gi][15]}}, smp[gi]};
    assign vol_ext    = {16'd0, vol};
    assign prod       = samp_ext * vol_ext;
    assign scaled[gi] = 20'(prod >>> 4);
  end

  // Next-state logic for pacer, FIFO bookkeeping, output words and flags.
  always_comb begin
    push      = in_valid & in_ready;
    fetch     = en && (div_cnt_q == CNT_FETCH);
    pop       = fetch && (level_q != '0);

    div_cnt_d = '0;
    if (en) begin
      div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + CW'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Outputs change only at the fetch edge; an empty fetch yields silence.
    lch_d = lch_q;
    rch_d = rch_q;
    if (fetch) begin
      lch_d = pop ? scaled[0] : '0;
      rch_d = pop ? scaled[1] : '0;
    end

    req_d = en && (div_cnt_q == CNT_LAST);

    // An empty fetch sets the flag and wins over a coincident clear.
    uf_d = uf_q;
    if (fetch && !pop) begin
      uf_d = 1'b1;
    end else if (clr) begin
      uf_d = 1'b0;
    end
  end

  // FIFO storage write; contents are don't-care after reset.
  always_ff @(posedge dac_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_lch, in_rch};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      div_cnt_q <= '0;
      lch_q     <= '0;
      rch_q     <= '0;
      req_q     <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      div_cnt_q <= div_cnt_d;
      lch_q     <= lch_d;
      rch_q     <= rch_d;
      req_q     <= req_d;
      uf_q      <= uf_d;
    end
  end

  assign level     = level_q;
  assign underflow = uf_q;
  assign dac_lch   = lch_q;
  assign dac_rch   = rch_q;
  assign dac_req   = req_q;

endmodule
